// File: rtl/vga_layer_mixer_if.sv
// Bundles the per-layer pixel inputs, configuration, timing inputs and composited
// VGA outputs of the layer mixer.
interface vga_layer_mixer_if #(
   parameter int unsigned LAYERS = 4
);
   logic [8*LAYERS-1:0] layer_rgb;
   logic [LAYERS-1:0]   layer_en;
   logic [LAYERS-1:0]   blink_mask;
   logic                mode;
   logic [7:0]          key_color;
   logic [7:0]          bg_color;
   logic                vidon_in;
   logic                hsync_in;
   logic                vsync_in;
   logic [2:0]          red;
   logic [2:0]          green;
   logic [1:0]          blue;
   logic                hsync;
   logic                vsync;
   logic                vidon;
   logic                blink_phase;

   modport master (
      output layer_rgb, layer_en, blink_mask, mode, key_color, bg_color,
      output vidon_in, hsync_in, vsync_in,
      input  red, green, blue, hsync, vsync, vidon, blink_phase
   );

   modport slave (
      input  layer_rgb, layer_en, blink_mask, mode, key_color, bg_color,
      input  vidon_in, hsync_in, vsync_in,
      output red, green, blue, hsync, vsync, vidon, blink_phase
   );
endinterface

// File: rtl/vga_layer_mixer.sv
// Two-stage VGA compositor: priority/OR mixing of N layers with colour key, per-layer
// enable and blink, configuration shadowed at frame start, syncs delayed to match.
module vga_layer_mixer #(
   parameter int unsigned LAYERS       = 4,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input logic             clk25,
   input logic             clr,
   vga_layer_mixer_if.slave mix
);

   // Stage 1
   logic [8*LAYERS-1:0] s1_rgb_q;
   logic [7:0]          s1_bg_q;
   logic                s1_vid_q, s1_hs_q, s1_vs_q;

   // Stage 2
   logic [7:0] pix_q, pix_d;
   logic       hs_q, vs_q, vid_q;

   // Frame-synchronous configuration and blink state
   logic [LAYERS-1:0] en_s_q, en_s_d;
   logic [LAYERS-1:0] blink_s_q, blink_s_d;
   logic              mode_s_q, mode_s_d;
   logic [7:0]        key_s_q, key_s_d;
   logic [7:0]        fcnt_q, fcnt_d;
   logic              phase_q, phase_d;

   logic              frame_start;
   logic [LAYERS-1:0] vis;
   logic [7:0]        or_pix, pri_pix;

   // s1_vs_q doubles as the registered vsync used for falling-edge detection.
   assign frame_start = s1_vs_q & ~mix.vsync_in;

   always_comb begin
      en_s_d    = en_s_q;
      blink_s_d = blink_s_q;
      mode_s_d  = mode_s_q;
      key_s_d   = key_s_q;
      fcnt_d    = fcnt_q;
      phase_d   = phase_q;
      if (frame_start) begin
         en_s_d    = mix.layer_en;
         blink_s_d = mix.blink_mask;
         mode_s_d  = mix.mode;
         key_s_d   = mix.key_color;
         if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
            fcnt_d  = 8'h00;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 8'h01;
         end
      end
   end

   always_comb begin
      vis     = en_s_q & (~blink_s_q | {LAYERS{phase_q}});
      or_pix  = 8'h00;
      pri_pix = s1_bg_q;
      // Walk from lowest to highest priority so the lowest opaque index wins.
      for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
         if (vis[i]) begin
            or_pix = or_pix | s1_rgb_q[8*i +: 8];
            if (s1_rgb_q[8*i +: 8] != key_s_q) pri_pix = s1_rgb_q[8*i +: 8];
         end
      end
      if (!s1_vid_q)     pix_d = 8'h00;
      else if (mode_s_q) pix_d = pri_pix;
      else               pix_d = or_pix;
   end

   always_ff @(posedge clk25) begin
      if (clr) begin
         s1_rgb_q  <= '0;
         s1_bg_q   <= 8'h00;
         s1_vid_q  <= 1'b0;
         s1_hs_q   <= 1'b1;
         s1_vs_q   <= 1'b1;
         pix_q     <= 8'h00;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         vid_q     <= 1'b0;
         en_s_q    <= '1;
         blink_s_q <= '0;
         mode_s_q  <= 1'b0;
         key_s_q   <= 8'h00;
         fcnt_q    <= 8'h00;
         phase_q   <= 1'b1;
      end else begin
         s1_rgb_q  <= mix.layer_rgb;
         s1_bg_q   <= mix.bg_color;
         s1_vid_q  <= mix.vidon_in;
         s1_hs_q   <= mix.hsync_in;
         s1_vs_q   <= mix.vsync_in;
         pix_q     <= pix_d;
         hs_q      <= s1_hs_q;
         vs_q      <= s1_vs_q;
         vid_q     <= s1_vid_q;
         en_s_q    <= en_s_d;
         blink_s_q <= blink_s_d;
         mode_s_q  <= mode_s_d;
         key_s_q   <= key_s_d;
         fcnt_q    <= fcnt_d;
         phase_q   <= phase_d;
      end
   end

   assign mix.red         = pix_q[7:5];
   assign mix.green       = pix_q[4:2];
   assign mix.blue        = pix_q[1:0];
   assign mix.hsync       = hs_q;
   assign mix.vsync       = vs_q;
   assign mix.vidon       = vid_q;
   assign mix.blink_phase = phase_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer: directed scenarios plus randomized traffic
// checked against a frame/pixel-level behavioural model.
module tb_vga_layer_mixer;
   localparam int L  = 4;
   localparam int BF = 2;

   logic clk25 = 1'b0;
   logic clr;
   always #20 clk25 = ~clk25;

   vga_layer_mixer_if #(.LAYERS(L)) bus ();

   vga_layer_mixer #(.LAYERS(L), .BLINK_FRAMES(BF)) dut (
      .clk25 (clk25),
      .clr   (clr),
      .mix   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Model: what the pipeline holds one cycle back, and the current frame configuration
   logic [7:0]   h_pix [L];
   logic [7:0]   h_bg;
   logic         h_vid, h_hs, h_vs;
   logic [7:0]   e_pix;
   logic         e_hs, e_vs, e_vid;
   logic [L-1:0] m_en, m_blink;
   logic         m_mode;
   logic [7:0]   m_key;
   int           m_cnt;
   logic         m_phase;

   function automatic logic [7:0] compose();
      logic [7:0] acc;
      bit         found;
      bit         visible;
      acc   = 8'h00;
      found = 0;
      if (!h_vid) return 8'h00;
      for (int i = 0; i < L; i++) begin
         visible = m_en[i] && (!m_blink[i] || m_phase);
         if (!m_mode) begin
            if (visible) acc = acc | h_pix[i];
         end else if (visible && !found && h_pix[i] != m_key) begin
            acc   = h_pix[i];
            found = 1;
         end
      end
      if (m_mode && !found) acc = h_bg;
      return acc;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < L; i++) h_pix[i] = 8'h00;
      h_bg = 8'h00; h_vid = 0; h_hs = 1; h_vs = 1;
      e_pix = 8'h00; e_hs = 1; e_vs = 1; e_vid = 0;
      m_en = '1; m_blink = '0; m_mode = 0; m_key = 8'h00; m_cnt = 0; m_phase = 1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] out_pix();
      return {bus.red, bus.green, bus.blue};
   endfunction

   // One clock: advance the model with the inputs sampled at this edge, then check.
   task automatic step();
      @(posedge clk25);
      if (clr) begin
         model_reset();
      end else begin
         e_pix = compose();
         e_hs  = h_hs;
         e_vs  = h_vs;
         e_vid = h_vid;
         if (h_vs && !bus.vsync_in) begin
            m_en    = bus.layer_en;
            m_blink = bus.blink_mask;
            m_mode  = bus.mode;
            m_key   = bus.key_color;
            if (m_cnt == BF - 1) begin
               m_cnt   = 0;
               m_phase = !m_phase;
            end else begin
               m_cnt++;
            end
         end
         for (int i = 0; i < L; i++) h_pix[i] = bus.layer_rgb[8*i +: 8];
         h_bg  = bus.bg_color;
         h_vid = bus.vidon_in;
         h_hs  = bus.hsync_in;
         h_vs  = bus.vsync_in;
      end
      #1;
      chk("pix",   out_pix(),               e_pix);
      chk("hsync", {7'd0, bus.hsync},       {7'd0, e_hs});
      chk("vsync", {7'd0, bus.vsync},       {7'd0, e_vs});
      chk("vidon", {7'd0, bus.vidon},       {7'd0, e_vid});
      chk("phase", {7'd0, bus.blink_phase}, {7'd0, m_phase});
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic frame_pulse();
      bus.vsync_in = 1'b0;
      step();
      bus.vsync_in = 1'b1;
      step();
   endtask

   task automatic set_layers(input logic [7:0] l0, l1, l2, l3);
      bus.layer_rgb = {l3, l2, l1, l0};
   endtask

   initial begin
      model_reset();
      clr            = 1'b1;
      bus.layer_rgb  = '0;
      bus.layer_en   = '1;
      bus.blink_mask = '0;
      bus.mode       = 1'b0;
      bus.key_color  = 8'h00;
      bus.bg_color   = 8'h00;
      bus.vidon_in   = 1'b0;
      bus.hsync_in   = 1'b1;
      bus.vsync_in   = 1'b1;
      steps(2);
      chk("rst_pix", out_pix(), 8'h00);
      chk("rst_hs_vs_vid_ph", {4'd0, bus.hsync, bus.vsync, bus.vidon, bus.blink_phase}, 8'h0D);
      #1 clr = 1'b0;

      // Legacy OR after reset, with hsync echo
      set_layers(8'hE0, 8'h03, 8'h00, 8'h00);
      bus.vidon_in = 1'b1;
      bus.hsync_in = 1'b0;
      steps(2);
      chk("or_e3", out_pix(), 8'hE3);
      chk("hs_echo", {7'd0, bus.hsync}, 8'h00);
      bus.hsync_in = 1'b1;
      steps(2);

      // Priority mode with transparent key and background
      bus.mode      = 1'b1;
      bus.key_color = 8'h00;
      bus.bg_color  = 8'h01;
      set_layers(8'h00, 8'h1C, 8'h00, 8'h00);
      frame_pulse();
      step();
      chk("pri_1c", out_pix(), 8'h1C);
      set_layers(8'h00, 8'h00, 8'h00, 8'h00);
      steps(2);
      chk("pri_bg", out_pix(), 8'h01);

      // Mid-frame enable/mode change waits for the next frame start
      set_layers(8'h00, 8'h04, 8'h00, 8'h00);
      bus.layer_en = 4'b0001;
      bus.mode     = 1'b0;
      steps(3);
      chk("en_held", out_pix(), 8'h04);
      frame_pulse();
      step();
      chk("en_applied", out_pix(), 8'h00);
      set_layers(8'h40, 8'h04, 8'h00, 8'h00);
      steps(2);
      chk("en_l0_only", out_pix(), 8'h40);

      // Blink: toggles on frame starts 2, 4, 6 counted from reset
      clr = 1'b1;
      step();
      #1 clr = 1'b0;
      bus.layer_en   = 4'b1111;
      bus.blink_mask = 4'b0001;
      set_layers(8'hFF, 8'h00, 8'h00, 8'h00);
      for (int f = 1; f <= 6; f++) begin
         frame_pulse();
         steps(2);
         chk("blink_phase", {7'd0, bus.blink_phase}, {7'd0, ((f / 2) % 2) == 0});
         chk("blink_pix", out_pix(), ((f / 2) % 2) == 0 ? 8'hFF : 8'h00);
      end

      // Blanking forces black
      bus.blink_mask = 4'b0000;
      bus.vidon_in   = 1'b0;
      set_layers(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      steps(2);
      chk("blank_pix", out_pix(), 8'h00);
      chk("blank_vid", {7'd0, bus.vidon}, 8'h00);

      // Reset coincident with a frame-start edge: reset wins
      bus.vidon_in   = 1'b1;
      bus.mode       = 1'b1;
      bus.layer_en   = 4'b0010;
      bus.blink_mask = 4'b0001;
      bus.hsync_in   = 1'b0;
      bus.vsync_in   = 1'b0;
      clr            = 1'b1;
      step();
      chk("clr_pix", out_pix(), 8'h00);
      chk("clr_sync", {6'd0, bus.hsync, bus.vsync}, 8'h03);
      #1 clr = 1'b0;
      steps(3);
      chk("clr_shadow_or", out_pix(), 8'hFF);
      bus.vsync_in = 1'b1;
      bus.hsync_in = 1'b1;
      steps(2);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < L; i++) begin
            logic [7:0] pick;
            pick = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            bus.layer_rgb[8*i +: 8] = pick;
         end
         bus.bg_color   = 8'($urandom);
         bus.vidon_in   = ($urandom_range(0, 7) != 0);
         bus.hsync_in   = ($urandom_range(0, 5) != 0);
         bus.vsync_in   = ($urandom_range(0, 9) != 0);
         bus.layer_en   = L'($urandom);
         bus.blink_mask = L'($urandom);
         bus.mode       = 1'($urandom);
         bus.key_color  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         clr            = ($urandom_range(0, 99) == 0);
         step();
      end
      clr = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised, pipelined compositor that merges N VGA display layers (playfield, clock, tip overlay, …) into the single 8-bit RGB output driving the VGA pins. It sits between the per-layer renderers and the board outputs, replacing the plain bitwise OR of layer colours. It adds priority compositing with a transparent colour key, per-layer enable and blink, and frame-synchronous configuration updates. Sync signals are delayed to stay aligned with the pixel pipeline.

## Interface
Parameters:
- LAYERS, 4: number of input layers (1..8); layer 0 has the highest priority.
- BLINK_FRAMES, 30: frames per blink half-period (2..255).

Ports (one clock `clk25`; reset `clr` is synchronous and active-high):
- clk25  in  1  pixel clock, 25 MHz.
- clr  in  1  synchronous active-high reset.
- layer_rgb  in  8*LAYERS  packed pixels; layer i at [8i+7:8i], format {R[2:0],G[2:0],B[1:0]}.
- layer_en  in  LAYERS  requested enable mask; shadowed at frame start.
- blink_mask  in  LAYERS  requested blink mask; shadowed at frame start.
- mode  in  1  requested mode: 0 = OR (legacy), 1 = priority; shadowed at frame start.
- key_color  in  8  transparent colour for priority mode; shadowed at frame start.
- bg_color  in  8  background for priority mode when no layer is opaque; used live, not shadowed.
- vidon_in, hsync_in, vsync_in  in  1 each  from the VGA timing generator; syncs are active-low.
- red  out  3,  green  out  3,  blue  out  2  composited pixel.
- hsync, vsync  out  1  sync delayed by 2 cycles.
- vidon  out  1  vidon_in delayed by 2 cycles.
- blink_phase  out  1  1 = blinking layers visible.

## Operation
- Frame start: a falling edge of vsync_in, detected against a registered copy whose reset value is 1.
- Shadow registers: at frame start, load en_s, blink_s, mode_s and key_s from layer_en, blink_mask, mode and key_color. Between frame starts the inputs are ignored.
- Shadow reset values: en_s = all ones, blink_s = 0, mode_s = 0, key_s = 8'h00. After reset the block therefore behaves as the legacy OR of all layers.
- Blink counter fcnt, 8 bits, reset 0. Advances only at frame start.
  - If fcnt == BLINK_FRAMES-1: fcnt returns to 0 and blink_phase toggles.
  - Otherwise fcnt increments.
- blink_phase resets to 1.
- Layer i is visible when en_s[i] && (!blink_s[i] || blink_phase).
- Stage 1 registers layer_rgb, vidon_in, hsync_in and vsync_in.
- Stage 2 computes and registers the output pixel:
  - mode_s = 0: OR of all visible layers; key_s is ignored.
  - mode_s = 1: the lowest-index visible layer whose pixel != key_s; if none exists, bg_color. bg_color is sampled in stage 1 alongside the layer pixels.
  - If the stage-1 vidon is 0, the output pixel is 8'h00 in either mode.
- Shadow loads and blink updates take effect on the clock edge that detects frame start. Pixels already in flight use the new values from the next stage-2 evaluation. This is harmless because vsync falls during blanking.
- Reset mid-frame: every register returns to its reset value on the next edge. The outputs are blanked, and the syncs go inactive (1) until the pipeline refills.

## Timing
- Latency is 2 cycles for pixel, hsync, vsync and vidon; all four stay mutually aligned.
- Reset values: red/green/blue = 0, hsync = 1, vsync = 1, vidon = 0, blink_phase = 1. Stage-1 registers reset to pixel 0, vidon 0 and syncs 1.
- Throughput is one pixel per clock with no stalls.
- If clr and a frame-start edge occur in the same cycle, clr wins: no shadow load and no counter advance.
- The blink period is 2*BLINK_FRAMES frames; the first toggle comes BLINK_FRAMES frame starts after reset.

## Test plan
- Reset, then layer0 = 8'hE0, layer1 = 8'h03, vidon_in = 1 -> after 2 cycles {red,green,blue} = 8'hE3 (OR mode); hsync/vsync echo their inputs with 2-cycle delay.
- Drive mode = 1, key_color = 8'h00, then pulse vsync_in low. Layer0 = 8'h00, layer1 = 8'h1C, bg = 8'h01 -> output 8'h1C. Then set layer1 = 8'h00 -> output 8'h01.
- Change layer_en to 4'b0001 mid-frame -> no change until the next vsync_in fall; after it, only layer 0 contributes.
- BLINK_FRAMES = 2, blink_mask = 4'b0001, layer0 = 8'hFF -> blink_phase toggles at frame starts 2, 4, 6. Output is 8'h00 (OR mode, others 0) while blink_phase = 0.
- vidon_in = 0 with all layers 8'hFF -> output 8'h00 two cycles later; vidon = 0.
- Assert clr for 1 cycle mid-line, coincident with a vsync_in fall -> next cycle all outputs are at reset values, fcnt = 0, shadows at reset values.
